// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// default widths and accept-time legality helpers.
package lsu_pkg;

  localparam int          LSU_ADDR_W   = 16;
  localparam int          LSU_DATA_W   = 32;
  localparam logic [15:0] LSU_MAX_ADDR = 16'hFFFC;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  // Stores only have signed-size encodings; unsigned forms are loads only.
  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!wr) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: load extract/extend and sub-word store merge.
// Sub-word data always lives in the low bytes of the 4-byte window.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] raw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word
);

  always_comb begin
    ld_data = raw;
    case (funct3)
      F3_B:    ld_data = {{(DATA_W-8){raw[7]}}, raw[7:0]};
      F3_H:    ld_data = {{(DATA_W-16){raw[15]}}, raw[15:0]};
      F3_BU:   ld_data = {{(DATA_W-8){1'b0}}, raw[7:0]};
      F3_HU:   ld_data = {{(DATA_W-16){1'b0}}, raw[15:0]};
      default: ld_data = raw;
    endcase
  end

  // Upper bytes of the old word pass through untouched.
  always_comb begin
    st_word = raw;
    case (funct3)
      F3_B:    st_word[7:0]  = wdata[7:0];
      F3_H:    st_word[15:0] = wdata[15:0];
      F3_W:    st_word       = wdata;
      default: st_word       = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the memory stage and a byte-addressed 32-bit SRAM.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int                ADDR_W   = LSU_ADDR_W,
  parameter int                DATA_W   = LSU_DATA_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = LSU_MAX_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              sram_en,
  output logic              sram_wr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              acc_err;
  logic [DATA_W-1:0] ld_data, st_word;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3  (f3_q),
    .raw     (sram_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_comb begin
    acc_err = !f3_legal(req_wr, req_funct3) || (req_addr > MAX_ADDR);
`ifdef LSU_MISALIGN_TRAP_EN
    acc_err = acc_err || misaligned(req_funct3, req_addr[1:0]);
`endif
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        wr_d    = req_wr;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = acc_err;
        if (acc_err)                          state_d = S_RESP;
        else if (req_wr && req_funct3 == F3_W) state_d = S_WR;
        else                                   state_d = S_RD;
      end
      S_RD:  state_d = S_CAP;
      // wdata_q doubles as the write-data register, so the merge lands there.
      S_CAP: if (wr_q) begin
        wdata_d = st_word;
        state_d = S_WR;
      end else begin
        rdata_d = ld_data;
        state_d = S_RESP;
      end
      S_WR:   state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // SRAM strobes come from the state register alone.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign sram_en    = (state_q == S_RD) || (state_q == S_WR);
  assign sram_wr    = (state_q == S_WR);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: byte-array SRAM model, byte-level reference
// memory, and a monitor that checks data, error, latency and SRAM traffic.
`timescale 1ns/1ps
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [15:0] req_addr = 16'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b1;
  logic        req_ready, resp_valid, resp_err, sram_en, sram_wr;
  logic [31:0] resp_rdata, sram_wdata, sram_rdata;
  logic [15:0] sram_addr;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .sram_en(sram_en),
    .sram_wr(sram_wr), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  logic        mem_init = 1'b0;
  int          n_rd = 0, n_wr = 0, cyc = 0;
  int          checks = 0, fails = 0, n_done = 0, issued = 0;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h100:   return 8'h80;
      'h101:   return 8'h7F;
      'h102:   return 8'h12;
      'h103:   return 8'h34;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // SRAM: full 4-byte window read/write at addr, read data one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
      mem_init <= 1'b1;
    end else if (sram_en) begin
      if (sram_wr) begin
        for (int k = 0; k < 4; k++) mem[16'(sram_addr + 16'(k))] <= sram_wdata[8*k +: 8];
        n_wr <= n_wr + 1;
      end else begin
        for (int k = 0; k < 4; k++) sram_rdata[8*k +: 8] <= mem[16'(sram_addr + 16'(k))];
        n_rd <= n_rd + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s (bound expired)", name);
  endtask

  // Reference: RISC-V load/store semantics over a flat byte array.
  function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                 input logic [15:0] a, input logic [31:0] wd);
    exp_t   e;
    int     size;
    logic   legal;
    longint v;
    e.rdata = 32'd0; e.err = 1'b0; e.lat = 1; e.acc = 0; e.nrd = 0; e.nwr = 0;
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (a > 16'hFFFC) legal = 1'b0;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((int'(a) % size) != 0) legal = 1'b0;
`endif
    if (!legal) begin
      e.err = 1'b1;
    end else if (!wr) begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(ref_mem[16'(a + 16'(i))]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
      e.rdata = v[31:0];
      e.lat = 3; e.nrd = 1;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[16'(a + 16'(i))] = wd[8*i +: 8];
      e.lat = (size == 4) ? 2 : 4;
      e.nrd = (size < 4) ? 1 : 0;
      e.nwr = 1;
    end
    return e;
  endfunction

  // Monitor: first-high cycle, stability while stalled, compare on consume.
  initial begin : monitor
    logic        vprev;
    int          first_cyc, rd_base, wr_base;
    logic [31:0] hold_rdata;
    logic        hold_err;
    exp_t        e;
    vprev = 1'b0; first_cyc = 0; rd_base = 0; wr_base = 0;
    hold_rdata = '0; hold_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        vprev = 1'b0; rd_base = n_rd; wr_base = n_wr;
      end else if (resp_valid) begin
        if (!vprev) begin
          first_cyc = cyc; hold_rdata = resp_rdata; hold_err = resp_err; vprev = 1'b1;
        end else begin
          chk("stall_rdata", resp_rdata, hold_rdata);
          chk("stall_err", {31'd0, resp_err}, {31'd0, hold_err});
          chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
          chk("stall_sram_en", {31'd0, sram_en}, 32'd0);
        end
        if (resp_ready) begin
          if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_resp rdata=%h err=%0b", resp_rdata, resp_err);
          end else begin
            e = q.pop_front();
            chk("rdata", resp_rdata, e.rdata);
            chk("err", {31'd0, resp_err}, {31'd0, e.err});
            chk("latency", first_cyc - e.acc + 1, e.lat);
            chk("sram_reads", n_rd - rd_base, e.nrd);
            chk("sram_writes", n_wr - wr_base, e.nwr);
          end
          rd_base = n_rd; wr_base = n_wr; vprev = 1'b0;
          n_done++;
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [15:0] a,
                       input logic [31:0] wd);
    exp_t e;
    int   t;
    t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!req_ready) fail_now("req_ready_wait");
    req_valid = 1'b1; req_wr = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e = model(wr, f3, a, wd);
    e.acc = cyc;
    q.push_back(e);
    issued++;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (n_done < issued && t < 100) begin @(posedge clk); #1; t++; end
    if (n_done < issued) fail_now("resp_wait");
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [15:0] a,
                        input logic [31:0] wd);
    issue(wr, f3, a, wd);
    wait_done();
  endtask

  task automatic check_mem(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) chk("mem", {24'd0, mem[16'(a + 16'(i))]}, {24'd0, ref_mem[16'(a + 16'(i))]});
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
    chk("rst_sram_wr", {31'd0, sram_wr}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_sram_addr", {16'd0, sram_addr}, 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
  endtask

  initial begin : stim
    int          t, nwr0;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed loads/stores over the preloaded window.
    do_req(1'b0, 3'b010, 16'h0100, 32'h0);         // LW
    do_req(1'b0, 3'b000, 16'h0100, 32'h0);         // LB
    do_req(1'b0, 3'b100, 16'h0100, 32'h0);         // LBU
    do_req(1'b0, 3'b001, 16'h0102, 32'h0);         // LH
    do_req(1'b0, 3'b101, 16'h0100, 32'h0);         // LHU
    do_req(1'b1, 3'b000, 16'h0101, 32'hAABBCCDD);  // SB
    check_mem(16'h0100, 6);
    do_req(1'b0, 3'b010, 16'h0100, 32'h0);         // LW after SB
    do_req(1'b1, 3'b001, 16'h0106, 32'h1234BEEF);  // SH
    do_req(1'b1, 3'b010, 16'h0108, 32'hCAFEF00D);  // SW
    check_mem(16'h0104, 12);
    do_req(1'b0, 3'b010, 16'hFFFE, 32'h0);         // out of range
    do_req(1'b0, 3'b010, 16'hFFFC, 32'h0);         // highest legal base
    do_req(1'b0, 3'b011, 16'h0100, 32'h0);         // illegal load funct3
    do_req(1'b1, 3'b100, 16'h0100, 32'h0);         // illegal store funct3
    do_req(1'b0, 3'b010, 16'h0102, 32'h0);         // misaligned LW
    do_req(1'b0, 3'b001, 16'h0101, 32'h0);         // misaligned LH

    // Consumer stall: response must hold, nothing else moves.
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 16'h0104, 32'h0);
    t = 0;
    while (!resp_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (!resp_valid) fail_now("stall_valid_wait");
    repeat (5) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    wait_done();
    chk("idle_after_consume", {31'd0, req_ready}, 32'd1);

    // Reset during CAP of an SH: nothing written, no response.
    req_valid = 1'b1; req_wr = 1'b1; req_funct3 = 3'b001;
    req_addr = 16'h0200; req_wdata = 32'h00005566;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nwr0 = n_wr;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_write", n_wr - nwr0, 32'd0);
    chk("rst_req_ready_after", {31'd0, req_ready}, 32'd1);
    check_mem(16'h0200, 4);

    // Randomized mix across a small window and the top of memory.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = 16'hFFF8 + 16'($urandom_range(0, 7));
      else                           a = 16'h0100 + 16'($urandom_range(0, 31));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    check_mem(16'h0100, 36);
    check_mem(16'hFFF8, 8);
    chk("queue_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit between the core's memory stage and the byte-addressed 32-bit `sram`.
- Accepts one RISC-V load/store per handshake and decodes funct3 for byte/half/word size and signedness.
- Sign/zero-extends load data.
- Performs read-modify-write for SB/SH, because the SRAM always writes 4 bytes at addr..addr+3.
- Returns one response per request over a valid/ready handshake.

Parameters:
ADDR_W, 16, SRAM byte-address width
DATA_W, 32, data width; only 32 supported
MAX_ADDR, 16'hFFFC, highest legal access base address (addr+3 must not exceed 0xFFFF)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_wr  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data; low 1/2/4 bytes used
resp_valid  out  1  response present; held until accepted
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3, out-of-range address, or misaligned (see feature)
sram_en  out  1  to `sram` enable
sram_wr  out  1  to `sram` wr
sram_addr  out  ADDR_W  to `sram` addr
sram_wdata  out  DATA_W  to `sram` data_in
sram_rdata  in  DATA_W  from `sram` data_out; valid the cycle after a read enable

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except req_ready=1. Latched request fields cleared.
- Accept: a request is accepted on a posedge where req_valid & req_ready. Fields are latched.
- Error check at accept; any of the following goes to RESP with resp_err=1 and no SRAM access:
  - illegal funct3: loads other than 000/001/010/100/101; stores other than 000/001/010.
  - req_addr > MAX_ADDR.
- Addressing:
  - sram_addr = latched addr for every access; there is no lane shifting.
  - Sub-word data always occupies the low bytes of the 4-byte window at addr.
- States: IDLE, RD, CAP, WR, RESP (encoding in package).
  - IDLE -> RD for loads, SB, SH.
  - IDLE -> WR for SW.
  - IDLE -> RESP on error.
  - RD: sram_en=1, sram_wr=0. Next state CAP.
  - CAP: sram_rdata valid.
    - Load: extract the low 1/2/4 bytes and sign- or zero-extend into the resp_rdata register; next state RESP.
    - SB/SH: merge req_wdata[7:0] or [15:0] over the low byte(s) of sram_rdata into the sram_wdata register; upper bytes unchanged; next state WR.
  - WR: sram_en=1, sram_wr=1. Next state RESP.
  - RESP: resp_valid=1, and resp_rdata/resp_err are stable until resp_ready. On resp_valid & resp_ready, next state IDLE and resp_valid drops.
- sram_en/sram_wr are decoded from the state register only; no combinational path from req_* or resp_ready.
- Latency (accept edge = cycle 0, resp_valid first high):
  - loads: cycle 3
  - SW: cycle 2
  - SB/SH: cycle 4
  - error: cycle 1
- Exactly one SRAM read per load or sub-word store; exactly one SRAM write per store.
- Throughput: no new request is accepted until the response is consumed (req_ready=0 outside IDLE).
- Reset mid-operation: state returns to IDLE immediately and sram_en drops.
  - A WR that has not reached its posedge is not performed.
  - A partially completed RMW leaves memory unchanged.
  - The pending response is discarded.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, are rejected at accept with resp_err=1 and no SRAM access.
- Undefined: misaligned accesses proceed normally; the byte-addressed SRAM handles them.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101)
  - state enum
  - ADDR_W/DATA_W defaults
  - MAX_ADDR
- Sub-module lsu_align (combinational):
  - load extract/extend (funct3, raw word -> rdata)
  - store merge (funct3, old word, wdata -> new word)
  - FSM stays in lsu.

Test Plan:
- Preload mem[0x100..0x103]=80,7F,12,34; LW 0x100 -> resp_rdata=0x34127F80, resp_err=0, resp_valid at cycle 3, one sram read.
- LB 0x100 -> 0xFFFFFF80; LBU 0x100 -> 0x00000080; LH 0x102 -> 0x00003412; LHU 0x100 -> 0x00007F80.
- SB 0x101, wdata 0xAABBCCDD -> mem[0x101]=DD, mem[0x102..0x104] unchanged, one read then one write, resp at cycle 4; following LW 0x100 -> 0x3412DD80.
- LW 0xFFFE -> resp_err=1 at cycle 1, sram_en never high. Funct3 3'b011 load -> resp_err=1. With LSU_MISALIGN_TRAP_EN: LW 0x102 -> err; without it: LW 0x102 returns bytes 0x102..0x105.
- Hold resp_ready=0 for 5 cycles after a LW -> resp_valid/resp_rdata stable, req_ready=0, no sram_en; then resp_ready=1 -> IDLE next cycle.
- Drive rst=0 during CAP of SH 0x200 -> outputs reset asynchronously, no sram write, mem[0x200..0x203] unchanged, req_ready=1 after release.
